// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan logic
//   SEG_LUT      hex nibble to active-low abcdefg pattern (bit6 = a)
//   SEG_BLANK    all segments off
//   AN_OFF       all anodes off
//   slot_state_t per-slot display state (blanking window or digit on)
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef enum logic {ST_BLANK, ST_ON} slot_state_t;
endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: slot counter and digit rotation for multiplexed scan logic
//   clk, rst_n  clock, async active-low reset
//   idx         digit currently owning the slot
//   blank       slot is inside its leading all-off window
//   boundary    last cycle of the digit-3 slot (frame end)
module seg7_slot_timer #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] idx,
  output logic       blank,
  output logic       boundary
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  assign blank = cnt < CW'(BLANK_CYCLES);
  assign boundary = wrap && idx == 2'd3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 1'b1 : idx;
    end
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode seven-segment scan controller
//   clk, rst_n  clock, async active-low reset
//   value_in    hex value, nibble k drives digit k (digit 0 rightmost)
//   load        capture value_in/dp_in into the shadow register
//   digit_en    live per-digit enable
//   dp_in       per-digit decimal point, 1 = lit
//   an_out      active-low anodes, seg_out active-low abcdefg, dp_out active-low
//   frame_done  one-cycle pulse as the digit-3 slot ends
// Build option: LEADING_ZERO_SUPPRESS_EN darkens digits above the top non-zero nibble.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int NUM_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic        frame_done
);
  logic [1:0] idx;
  logic blank, boundary;
  logic [15:0] disp_val, shd_val;
  logic [3:0] disp_dp, shd_dp;
  logic pending;
  logic [NUM_DIGITS-1:0] lz_mask, en;
  slot_state_t state;
  logic lit;
  logic [3:0] an_nx;
  logic [6:0] seg_nx;
  logic dp_nx;
  seg7_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx     (idx),
    .blank   (blank),
    .boundary(boundary)
  );
  // A load on the boundary cycle bypasses the shadow so the new value is
  // shown in the very next frame instead of one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val <= '0;
      disp_dp <= '0;
      shd_val <= '0;
      shd_dp <= '0;
      pending <= 1'b0;
    end else if (boundary) begin
      disp_val <= load ? value_in : pending ? shd_val : disp_val;
      disp_dp <= load ? dp_in : pending ? shd_dp : disp_dp;
      pending <= 1'b0;
    end else if (load) begin
      shd_val <= value_in;
      shd_dp <= dp_in;
      pending <= 1'b1;
    end
  end
`ifdef LEADING_ZERO_SUPPRESS_EN
  assign lz_mask = {|disp_val[15:12], |disp_val[15:8], |disp_val[15:4], 1'b1};
`else
  assign lz_mask = '1;
`endif
  assign en = digit_en & lz_mask;
  always_comb begin
    state = blank ? ST_BLANK : ST_ON;
    lit = state == ST_ON && en[idx];
    an_nx = lit ? ~(4'b0001 << idx) : AN_OFF;
    seg_nx = lit ? SEG_LUT[disp_val[{idx, 2'b00} +: 4]] : SEG_BLANK;
    dp_nx = lit ? ~disp_dp[idx] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_out <= AN_OFF;
      seg_out <= SEG_BLANK;
      dp_out <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_out <= an_nx;
      seg_out <= seg_nx;
      dp_out <= dp_nx;
      frame_done <= boundary;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized self-checking bench against a frame-level display model
module tb_seg7_scan_ctrl;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * RD;
  localparam logic [6:0] REF [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic load = 1'b0;
  logic [3:0] digit_en = 4'hF;
  logic [3:0] dp_in = '0;
  logic [3:0] an_out;
  logic [6:0] seg_out;
  logic dp_out, frame_done;
  logic [12:0] got, exp_v;
  int tests = 0;
  int fails = 0;
  int p;
  logic [15:0] m_val, m_shd;
  logic [3:0] m_dp, m_shd_dp;
  bit m_pend;
  seg7_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .NUM_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
    .digit_en(digit_en), .dp_in(dp_in), .an_out(an_out), .seg_out(seg_out),
    .dp_out(dp_out), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  assign got = {an_out, seg_out, dp_out, frame_done};

  function automatic bit shown(int d);
`ifdef LEADING_ZERO_SUPPRESS_EN
    return d == 0 || (m_val >> (4 * d)) != 16'd0;
`else
    return d >= 0;
`endif
  endfunction

  // p = cycles elapsed since reset release; position within the frame follows from it
  task automatic tick();
    int c, d;
    bit lit, bnd;
    c = p % RD;
    d = (p / RD) % 4;
    lit = c >= BC && digit_en[d] && shown(d);
    bnd = (p % FR) == FR - 1;
    exp_v = {lit ? ~(4'b0001 << d) : 4'hF, lit ? REF[m_val[4*d +: 4]] : 7'h7F,
             lit ? ~m_dp[d] : 1'b1, bnd};
    if (bnd) begin
      if (load) begin m_val = value_in; m_dp = dp_in; end
      else if (m_pend) begin m_val = m_shd; m_dp = m_shd_dp; end
      m_pend = 0;
    end else if (load) begin
      m_shd = value_in; m_shd_dp = dp_in; m_pend = 1;
    end
    @(posedge clk);
    p++;
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    load = 1'b0;
    m_val = '0; m_shd = '0; m_dp = '0; m_shd_dp = '0; m_pend = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    p = 0;
  endtask

  task automatic test_reset();
    int first;
    @(posedge clk); #1;
    tests++;
    if (got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin fails++; $display("FAIL reset_state got=%b exp=%b", got, {4'hF, 7'h7F, 1'b1, 1'b0}); end
    reset_dut();
    first = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL reset_model p=%0d got=%b exp=%b", p, got, exp_v); end
      if (p <= 2) begin
        tests++;
        if (an_out !== 4'hF) begin fails++; $display("FAIL reset_blank p=%0d an=%b exp=1111", p, an_out); end
      end
      if (p == 3) begin
        tests++;
        if ({an_out, seg_out} !== {4'b1110, 7'b0000001}) begin fails++; $display("FAIL reset_first_digit an=%b seg=%b exp 1110 0000001", an_out, seg_out); end
      end
      if (frame_done && first < 0) first = p;
    end
    tests++;
    if (first != 32) begin fails++; $display("FAIL first_frame_done got=%0d exp=32", first); end
  endtask

  task automatic test_load();
    int lp;
    logic [6:0] es;
    reset_dut();
    lp = $urandom_range(3, 28);
    value_in = 16'h1A2F;
    dp_in = 4'b0100;
    while (p < 32) begin
      load = p == lp;
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL load_model p=%0d got=%b exp=%b", p, got, exp_v); end
      if (an_out != 4'hF) begin
        tests++;
        if (seg_out !== 7'b0000001) begin fails++; $display("FAIL load_early p=%0d seg=%b exp=0000001", p, seg_out); end
      end
    end
    load = 1'b0;
    for (int i = 0; i < FR; i++) begin
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL load_model p=%0d got=%b exp=%b", p, got, exp_v); end
      if (an_out != 4'hF) begin
        es = an_out == 4'b1110 ? 7'b0111000 : an_out == 4'b1101 ? 7'b0010010 :
             an_out == 4'b1011 ? 7'b0001000 : 7'b1001111;
        tests++;
        if ({seg_out, dp_out} !== {es, an_out != 4'b1011}) begin fails++; $display("FAIL load_frame an=%b seg=%b dp=%b exp seg=%b", an_out, seg_out, dp_out, es); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    dp_in = 4'b0000;
    while (p < 96) begin
      load = p == 70 || p == 80;
      value_in = p == 70 ? 16'h1111 : 16'h2222;
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL double_model p=%0d got=%b exp=%b", p, got, exp_v); end
    end
    load = 1'b0;
    for (int i = 0; i < FR; i++) begin
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL double_model p=%0d got=%b exp=%b", p, got, exp_v); end
      if (an_out != 4'hF) begin
        tests++;
        if (seg_out !== 7'b0010010) begin fails++; $display("FAIL double_last_wins seg=%b exp=0010010", seg_out); end
      end
    end
    for (int i = 0; i < 2 * FR && (p % FR) != FR - 1; i++) tick();
    v = 16'($urandom);
    value_in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    tests++;
    if (frame_done !== 1'b1) begin fails++; $display("FAIL boundary_pulse got=%b exp=1", frame_done); end
    for (int i = 0; i < FR; i++) begin
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL boundary_model p=%0d got=%b exp=%b", p, got, exp_v); end
      if (an_out == 4'b1110) begin
        tests++;
        if (seg_out !== REF[v[3:0]]) begin fails++; $display("FAIL boundary_load seg=%b exp=%b", seg_out, REF[v[3:0]]); end
      end
    end
  endtask

  task automatic test_digit_en();
    digit_en = 4'b0101;
    value_in = 16'($urandom) | 16'h1111;
    dp_in = 4'($urandom);
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3 * FR; i++) begin
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL en_model p=%0d got=%b exp=%b", p, got, exp_v); end
      tests++;
      if (an_out == 4'b1101 || an_out == 4'b0111) begin fails++; $display("FAIL en_disabled an=%b exp not 1101/0111", an_out); end
    end
    digit_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    value_in = 16'hBEEF;
    dp_in = 4'hF;
    while (p < 20) begin
      load = p == 3;
      tick();
    end
    load = 1'b0;
    tests++;
    if (an_out !== 4'b1011) begin fails++; $display("FAIL mid_pre an=%b exp=1011", an_out); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin fails++; $display("FAIL mid_async_blank got=%b exp=%b", got, {4'hF, 7'h7F, 1'b1, 1'b0}); end
    reset_dut();
    for (int i = 0; i < 2 * FR + 4; i++) begin
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL mid_model p=%0d got=%b exp=%b", p, got, exp_v); end
      if (an_out != 4'hF) begin
        tests++;
        if ({seg_out, dp_out} !== {7'b0000001, 1'b1}) begin fails++; $display("FAIL mid_lost seg=%b dp=%b exp 0000001 1", seg_out, dp_out); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : digit_en;
      load = $urandom_range(0, 15) == 0;
      value_in = 16'($urandom);
      dp_in = 4'($urandom);
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL random_model p=%0d got=%b exp=%b", p, got, exp_v); end
    end
    load = 1'b0;
    digit_en = 4'hF;
  endtask

`ifdef LEADING_ZERO_SUPPRESS_EN
  task automatic test_lzs();
    bit seen0, seen1;
    reset_dut();
    value_in = 16'h00A0;
    dp_in = 4'hF;
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 2 * FR + 1; i++) begin
      load = i == 3;
      tick();
    end
    load = 1'b0;
    for (int i = 0; i < FR; i++) begin
      tick();
      tests++;
      if (got !== exp_v) begin fails++; $display("FAIL lzs_model p=%0d got=%b exp=%b", p, got, exp_v); end
      tests++;
      if (an_out == 4'b0111 || an_out == 4'b1011) begin fails++; $display("FAIL lzs_suppress an=%b", an_out); end
      seen0 |= an_out == 4'b1110;
      seen1 |= an_out == 4'b1101;
    end
    tests++;
    if (!(seen0 && seen1)) begin fails++; $display("FAIL lzs_lit d0=%b d1=%b exp 1 1", seen0, seen1); end
    reset_dut();
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      tests++;
      if (an_out != 4'hF && {an_out, seg_out} !== {4'b1110, 7'b0000001}) begin fails++; $display("FAIL lzs_zero an=%b seg=%b exp 1110 0000001", an_out, seg_out); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_digit_en();
    test_reset_mid();
    test_random();
`ifdef LEADING_ZERO_SUPPRESS_EN
    test_lzs();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexes a 16-bit hex value onto the 4-digit common-anode seven-segment display of the Nexys3 board. A refresh counter rotates one active digit at a time. Anode-off blanking at each slot start suppresses ghosting. New values are double-buffered and swapped only at frame boundaries, so digits never tear. The block sits between the processor's display/debug register and the board pins, and owns the single shared segment bus.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); must be > BLANK_CYCLES
BLANK_CYCLES, 2000, cycles at slot start with all anodes off; must be >= 1
NUM_DIGITS, 4, digit count; fixed at 4 for this board

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
value_in  in  16  hex value to show; nibble k drives digit k, digit 0 rightmost
load  in  1  capture value_in and dp_in into shadow registers this cycle
digit_en  in  4  per-digit enable, 1 = digit may light; sampled live, not buffered
dp_in  in  4  per-digit decimal point, 1 = lit
an_out  out  4  anodes, active-low, bit k = digit k
seg_out  out  7  segments, active-low, bit6 = a .. bit0 = g
dp_out  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse when the digit-3 slot ends

Behaviour:
- Reset (async assert, sync release): an_out=4'b1111, seg_out=7'b1111111, dp_out=1, frame_done=0. Slot counter, digit index, display register, shadow register and pending flag all reset to 0.
- Slot counter runs 0..REFRESH_DIV-1 and wraps. On wrap, digit index advances 0→1→2→3→0.
- Per-slot FSM, two states, evaluated on the registered slot count:
  - BLANK (count < BLANK_CYCLES): an_out=1111, seg_out=1111111, dp_out=1.
  - ON: an_out has bit idx = 0 and all other bits 1. Exception: if digit_en[idx]=0, an_out stays 1111 for the whole slot.
- Segment encoding is active-low, abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- All outputs are registered. Pins reflect the counter/index state with exactly 1 cycle of latency.
- load=1 writes the shadow register (value + dp) and sets pending. A repeated load before the frame boundary overwrites the shadow; last write wins.
- Frame boundary is the digit-3 slot wrap.
  - At the boundary: if pending, display register <= shadow and pending is cleared.
  - frame_done pulses for one cycle, registered alongside the swap.
- load coinciding with the boundary: value_in/dp_in go straight to the display register and pending ends cleared. No stale shadow is shown.
- Reset asserted mid-frame: outputs blank immediately and the pending update is discarded.

Optional Feature:
LEADING_ZERO_SUPPRESS_EN
- Defined: digits above the most significant non-zero nibble are treated as disabled (anodes off for the whole slot). This is ANDed with digit_en. Digit 0 is never suppressed, so 0x0000 shows a single "0" and 0x00A0 lights digits 1 and 0 only. dp_in for a suppressed digit is ignored.
- Undefined: every enabled digit shows its nibble, including leading zeros.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry segment encoding constant table
  - SEG_BLANK=7'b1111111 and AN_OFF=4'b1111
  - the 2-state slot-state encoding
- One natural sub-module, seg7_slot_timer: slot counter, digit index, blank flag and frame-boundary strobe. It is reusable for the LED scan logic.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset then release with no load → an_out=1111 for 2 cycles, then an_out=1110 with seg_out=0000001 ("0"). frame_done first pulses 32 cycles after release.
- load value_in=16'h1A2F, dp_in=4'b0100 → nothing changes until the next frame_done. The following frame shows:
  - digit0: seg 0111000, an 1110
  - digit1: seg 0010010
  - digit2: seg 0001000, dp_out=0
  - digit3: seg 1001111
- Two loads in one frame (16'h1111, then 16'h2222) → only 2222 is ever displayed. load coinciding with the boundary cycle → that value shows in the immediately following frame.
- digit_en=4'b0101 → an_out never equals 1101 or 0111. Slots 1 and 3 stay 1111 for all 8 cycles.
- rst_n pulled low mid-slot of digit 2 with pending=1 → outputs go to blank in the same cycle. After release the display shows 0000 and the pending value is lost.
- With LEADING_ZERO_SUPPRESS_EN, value 16'h00A0 → anodes of digits 3 and 2 stay 1111, digits 1 and 0 light. Value 16'h0000 → only digit 0 lights, showing 0000001.
